// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared register-file widths and register index/data types
package regfile_mp_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard signals between the issue/writeback stages and the register file
interface regfile_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        r_en;
    logic [NUM_RD*ADDR_W-1:0] r_idx;
    logic [NUM_RD*DATA_W-1:0] r_data;
    logic [NUM_RD-1:0]        r_busy;
    logic                     w_en_a;
    logic [ADDR_W-1:0]        w_idx_a;
    logic [DATA_W-1:0]        w_data_a;
    logic                     w_en_b;
    logic [ADDR_W-1:0]        w_idx_b;
    logic [DATA_W-1:0]        w_data_b;
    logic                     busy_set;
    logic [ADDR_W-1:0]        busy_idx;
    logic [2**ADDR_W-1:0]     busy;

    modport master (
        output r_en, r_idx, w_en_a, w_idx_a, w_data_a, w_en_b, w_idx_b, w_data_b, busy_set, busy_idx,
        input  r_data, r_busy, busy
    );
    modport slave (
        input  r_en, r_idx, w_en_a, w_idx_a, w_data_a, w_en_b, w_idx_b, w_data_b, busy_set, busy_idx,
        output r_data, r_busy, busy
    );
endinterface

// File: rtl/regfile_mp_rd_port.sv
// regfile_mp_rd_port: one registered read port with write bypass (B over A) and optional hardwired-zero r0
module regfile_mp_rd_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              busy_i,
    input  logic              w_en_a_i,
    input  logic [ADDR_W-1:0] w_idx_a_i,
    input  logic [DATA_W-1:0] w_data_a_i,
    input  logic              w_en_b_i,
    input  logic [ADDR_W-1:0] w_idx_b_i,
    input  logic [DATA_W-1:0] w_data_b_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);
    logic              zero, hit_a, hit_b;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_d, busy_q;

    // select stored value or same-cycle write data; r0 forced to zero when hardwired
    always_comb begin
        zero   = (ZERO_R0 != 0) && (idx_i == '0);
        hit_a  = (BYPASS != 0) && w_en_a_i && (w_idx_a_i == idx_i);
        hit_b  = (BYPASS != 0) && w_en_b_i && (w_idx_b_i == idx_i);
        data_d = zero ? '0 : hit_b ? w_data_b_i : hit_a ? w_data_a_i : mem_data_i;
        busy_d = zero ? 1'b0 : busy_i;
    end

    // output registers update only when the port is enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else if (en_i) begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, per-port bypass and a RAW scoreboard
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d, set_v, clr_v;
    logic              we_a, we_b, set_ok;

    // write qualification and scoreboard next state; a set beats a same-cycle clear
    always_comb begin
        we_a   = bus.w_en_a && !((ZERO_R0 != 0) && (bus.w_idx_a == '0));
        we_b   = bus.w_en_b && !((ZERO_R0 != 0) && (bus.w_idx_b == '0));
        set_ok = bus.busy_set && !((ZERO_R0 != 0) && (bus.busy_idx == '0));
        set_v  = '0;
        clr_v  = '0;
        set_v[bus.busy_idx] = set_ok;
        if (bus.w_en_a) clr_v[bus.w_idx_a] = 1'b1;
        if (bus.w_en_b) clr_v[bus.w_idx_b] = 1'b1;
        busy_d = (busy_q & ~clr_v) | set_v;
    end

    // storage: B is assigned last so it wins an index collision with A
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < DEPTH; n++) mem_q[n] <= '0;
        end else begin
            if (we_a) mem_q[bus.w_idx_a] <= bus.w_data_a;
            if (we_b) mem_q[bus.w_idx_b] <= bus.w_data_b;
        end
    end

    // scoreboard register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign bus.busy = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              busy_sel;
        assign idx      = bus.r_idx[i*ADDR_W +: ADDR_W];
        // bypassing ports see the post-writeback scoreboard, others the pre-write state
        assign busy_sel = (BYPASS != 0) ? busy_d[idx] : busy_q[idx];
        regfile_mp_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS),
            .ZERO_R0(ZERO_R0)
        ) u_port (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      (bus.r_en[i]),
            .idx_i     (idx),
            .mem_data_i(mem_q[idx]),
            .busy_i    (busy_sel),
            .w_en_a_i  (bus.w_en_a),
            .w_idx_a_i (bus.w_idx_a),
            .w_data_a_i(bus.w_data_a),
            .w_en_b_i  (bus.w_en_b),
            .w_idx_b_i (bus.w_idx_b),
            .w_data_b_i(bus.w_data_b),
            .data_o    (bus.r_data[i*DATA_W +: DATA_W]),
            .busy_o    (bus.r_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors on a bypassing build (A) and a non-bypassing hardwired-r0 build (B)
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) ifa ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) ifb ();

    regfile_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    regfile_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    typedef struct packed {
        logic [2:0]  ren;
        logic [4:0]  i0, i1, i2;
        logic        wea;
        logic [4:0]  wia;
        logic [15:0] wda;
        logic        web;
        logic [4:0]  wib;
        logic [15:0] wdb;
        logic        bs;
        logic [4:0]  bi;
        logic [47:0] da;
        logic [2:0]  rba;
        logic [31:0] ba;
        logic [47:0] db;
        logic [2:0]  rbb;
        logic [31:0] bb;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ifa.r_en = v.ren;      ifb.r_en = v.ren;
        ifa.r_idx = {v.i2, v.i1, v.i0};
        ifb.r_idx = {v.i2, v.i1, v.i0};
        ifa.w_en_a = v.wea;    ifb.w_en_a = v.wea;
        ifa.w_idx_a = v.wia;   ifb.w_idx_a = v.wia;
        ifa.w_data_a = v.wda;  ifb.w_data_a = v.wda;
        ifa.w_en_b = v.web;    ifb.w_en_b = v.web;
        ifa.w_idx_b = v.wib;   ifb.w_idx_b = v.wib;
        ifa.w_data_b = v.wdb;  ifb.w_data_b = v.wdb;
        ifa.busy_set = v.bs;   ifb.busy_set = v.bs;
        ifa.busy_idx = v.bi;   ifb.busy_idx = v.bi;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = '0;
        //          ren     i0    i1    i2    wea wia   wda       web wib   wdb       bs  bi    A: data                 rbusy   busy        B: data                 rbusy   busy
        tbl[0]  = '{3'b001, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 16'hBEEF, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0000_0000_BEEF, 3'b000, 32'h0000_0000, 48'h0000_0000_0000, 3'b000, 32'h0000_0000};
        tbl[1]  = '{3'b111, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0000_BEEF_BEEF, 3'b000, 32'h0000_0000, 48'h0000_BEEF_BEEF, 3'b000, 32'h0000_0000};
        tbl[2]  = '{3'b010, 5'd3, 5'd7, 5'd0, 1'b1, 5'd7, 16'h1111, 1'b1, 5'd7, 16'h2222, 1'b0, 5'd0, 48'h0000_2222_BEEF, 3'b000, 32'h0000_0000, 48'h0000_0000_BEEF, 3'b000, 32'h0000_0000};
        tbl[3]  = '{3'b001, 5'd7, 5'd7, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0000_2222_2222, 3'b000, 32'h0000_0000, 48'h0000_0000_2222, 3'b000, 32'h0000_0000};
        tbl[4]  = '{3'b001, 5'd9, 5'd7, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd9, 48'h0000_2222_0000, 3'b001, 32'h0000_0200, 48'h0000_0000_0000, 3'b000, 32'h0000_0200};
        tbl[5]  = '{3'b001, 5'd9, 5'd7, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0000_2222_0000, 3'b001, 32'h0000_0200, 48'h0000_0000_0000, 3'b001, 32'h0000_0200};
        tbl[6]  = '{3'b001, 5'd9, 5'd7, 5'd0, 1'b1, 5'd9, 16'h0999, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0000_2222_0999, 3'b000, 32'h0000_0000, 48'h0000_0000_0000, 3'b001, 32'h0000_0000};
        tbl[7]  = '{3'b001, 5'd9, 5'd7, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd9, 16'h0AAA, 1'b1, 5'd9, 48'h0000_2222_0AAA, 3'b001, 32'h0000_0200, 48'h0000_0000_0999, 3'b000, 32'h0000_0200};
        tbl[8]  = '{3'b001, 5'd0, 5'd7, 5'd0, 1'b1, 5'd0, 16'hFFFF, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 48'h0000_2222_FFFF, 3'b001, 32'h0000_0201, 48'h0000_0000_0000, 3'b000, 32'h0000_0200};
        tbl[9]  = '{3'b111, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h0AAA_FFFF_FFFF, 3'b111, 32'h0000_0201, 48'h0AAA_0000_0000, 3'b100, 32'h0000_0200};
        tbl[10] = '{3'b101, 5'd31, 5'd0, 5'd0, 1'b1, 5'd31, 16'h5555, 1'b1, 5'd0, 16'h1234, 1'b0, 5'd0, 48'h1234_FFFF_5555, 3'b010, 32'h0000_0200, 48'h0000_0000_0000, 3'b000, 32'h0000_0200};
        tbl[11] = '{3'b011, 5'd31, 5'd0, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 48'h1234_1234_5555, 3'b000, 32'h0000_0200, 48'h0000_0000_5555, 3'b000, 32'h0000_0200};

        drive(idle);
        repeat (2) step();
        chk("reset_a_data", 64'(ifa.r_data), 64'h0);
        chk("reset_b_busy", 64'(ifb.busy), 64'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            drive(tbl[k]);
            step();
            chk($sformatf("v%0d_a_data", k), 64'(ifa.r_data), 64'(tbl[k].da));
            chk($sformatf("v%0d_a_rbusy", k), 64'(ifa.r_busy), 64'(tbl[k].rba));
            chk($sformatf("v%0d_a_busy", k), 64'(ifa.busy), 64'(tbl[k].ba));
            chk($sformatf("v%0d_b_data", k), 64'(ifb.r_data), 64'(tbl[k].db));
            chk($sformatf("v%0d_b_rbusy", k), 64'(ifb.r_busy), 64'(tbl[k].rbb));
            chk($sformatf("v%0d_b_busy", k), 64'(ifb.busy), 64'(tbl[k].bb));
        end

        // write r5 then assert reset between clock edges
        idle.ren = 3'b001; idle.i0 = 5'd5;
        idle.wea = 1'b1; idle.wia = 5'd5; idle.wda = 16'h1234;
        drive(idle);
        step();
        chk("rst_seq_a_bypass", 64'(ifa.r_data[15:0]), 64'h1234);
        idle.wea = 1'b0;
        drive(idle);
        step();
        chk("rst_seq_b_r5", 64'(ifb.r_data[15:0]), 64'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_a_data", 64'(ifa.r_data), 64'h0);
        chk("rst_async_a_busy", 64'(ifa.busy), 64'h0);
        chk("rst_async_b_busy", 64'(ifb.busy), 64'h0);
        chk("rst_async_b_data", 64'(ifb.r_data), 64'h0);
        #2 rst_n = 1'b1;
        step();
        chk("rst_after_a_r5", 64'(ifa.r_data[15:0]), 64'h0);
        chk("rst_after_b_r5", 64'(ifb.r_data[15:0]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
